addsub_seq_ctrl: RTL and testbench

Multi-cycle controller that computes a WIDTH-bit add or subtract by sequencing a single 4-bit adder-subtractor slice over WIDTH/4 cycles, least-significant nibble first, with the inter-slice carry held in a register. It sits between a requester with a valid/ready command port and a consumer with a valid/ready result port, and lets wide arithmetic reuse the 4-bit slice instead of instantiating a full-width adder.

---
 rtl/addsub_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_addsub_seq_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_seq_ctrl.sv
// addsub_seq_ctrl: WIDTH-bit add/subtract computed over WIDTH/4 cycles on a
// single 4-bit adder-subtractor slice. The least-significant nibble is done
// first, and the inter-slice carry is held in a register.
// WIDTH must be a multiple of 4 and at least 8.
// Optional feature: define ADDSUB_SEQ_OVF_EN to add the signed overflow
// port and its register.
module addsub_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry
`ifdef ADDSUB_SEQ_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sub_q, sub_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   result_q, result_d;
`ifdef ADDSUB_SEQ_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  // Bit offset of the current slice (idx * 4).
  logic [IDX_W+1:0]   bit_base;
  logic [3:0]         a_nib;
  logic [3:0]         b_nib;
  logic [4:0]         nib;

  // Slice datapath: one 4-bit add of a, b (inverted for subtract) and the carry register.
  always_comb begin
    bit_base = {idx_q, 2'b00};
    a_nib    = a_q[bit_base +: 4];
    b_nib    = b_q[bit_base +: 4] ^ {4{sub_q}};
    nib      = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
  end

  // Next-state and register-update logic. clear overrides every other transition.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    result_d = result_q;
`ifdef ADDSUB_SEQ_OVF_EN
    ovf_d    = ovf_q;
`endif

    if (clear) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            a_d     = a;
            b_d     = b;
            sub_d   = sub;
            // A carry-in of 1 together with the inverted B gives two's-complement subtract.
            carry_d = sub;
            idx_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          result_d[bit_base +: 4] = nib[3:0];
          carry_d                 = nib[4];
          idx_d                   = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = DONE;
`ifdef ADDSUB_SEQ_OVF_EN
            // The operands agree in sign on the effective B, and the result sign differs from A.
            ovf_d = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ sub_q)) &&
                    (nib[3] != a_q[WIDTH-1]);
`endif
          end
        end
        DONE: begin
          if (res_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand registers are reset along with the visible outputs; they are small flops, not a memory array.
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
`ifdef ADDSUB_SEQ_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      result_q <= result_d;
`ifdef ADDSUB_SEQ_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign result      = result_q;
  assign carry       = carry_q;
`ifdef ADDSUB_SEQ_OVF_EN
  assign overflow    = ovf_q;
`endif

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Testbench for addsub_seq_ctrl (WIDTH=16). Expected values come from a plain
// arithmetic reference model or from fixed constants.
// Overflow checks are compiled in when ADDSUB_SEQ_OVF_EN is defined.
module tb_addsub_seq_ctrl;

  localparam int W   = 16;
  localparam int LAT = W / 4;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         carry;
`ifdef ADDSUB_SEQ_OVF_EN
  logic         overflow;
`endif

  int n_checks;
  int n_fail;

  addsub_seq_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .carry       (carry)
`ifdef ADDSUB_SEQ_OVF_EN
    ,
    .overflow    (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: whole-word arithmetic.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                input logic ms, output logic [W-1:0] r,
                                output logic c, output logic v);
    logic [W:0] full;
    if (!ms) begin
      full = {1'b0, ma} + {1'b0, mb};
      r    = full[W-1:0];
      c    = full[W];
      v    = (ma[W-1] == mb[W-1]) && (r[W-1] != ma[W-1]);
    end else begin
      r = ma - mb;
      c = (ma >= mb);
      v = (ma[W-1] != mb[W-1]) && (r[W-1] != ma[W-1]);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command and let it be accepted on the next edge.
  task automatic launch(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is,
                        input string tag);
    n_checks++;
    if (start_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s start_ready before accept: got %b want 1", tag, start_ready);
    end
    a = ia; b = ib; sub = is; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
  endtask

  // Wait for res_valid (bounded); lat = cycles since the accept edge.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (res_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // Check latency and result fields, then complete the handshake.
  task automatic collect(input logic [W-1:0] er, input logic ec, input logic ev,
                         input string tag);
    int lat;
    wait_valid(lat);
    n_checks++;
    if (lat != LAT) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, LAT);
    end
    n_checks++;
    if (result !== er) begin
      n_fail++;
      $display("FAIL %s result: got %h want %h", tag, result, er);
    end
    n_checks++;
    if (carry !== ec) begin
      n_fail++;
      $display("FAIL %s carry: got %b want %b", tag, carry, ec);
    end
`ifdef ADDSUB_SEQ_OVF_EN
    n_checks++;
    if (overflow !== ev) begin
      n_fail++;
      $display("FAIL %s overflow: got %b want %b", tag, overflow, ev);
    end
`else
    if (ev === 1'bx) $display("unexpected x in expected overflow for %s", tag);
`endif
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s return to idle: res_valid=%b start_ready=%b want 0/1",
               tag, res_valid, start_ready);
    end
  endtask

  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is,
                       input logic [W-1:0] er, input logic ec, input logic ev,
                       input string tag);
    launch(ia, ib, is, tag);
    collect(er, ec, ev, tag);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0;
    #3;
    n_checks++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0 || result !== '0 || carry !== 1'b0) begin
      n_fail++;
      $display("FAIL reset values: start_ready=%b res_valid=%b result=%h carry=%b want 1/0/0000/0",
               start_ready, res_valid, result, carry);
    end
`ifdef ADDSUB_SEQ_OVF_EN
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset overflow: got %b want 0", overflow);
    end
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    do_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, "add_00ff_0001");
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "add_ffff_0001");
    do_op(16'h1234, 16'h0235, 1'b1, 16'h0FFF, 1'b1, 1'b0, "sub_1234_0235");
    do_op(16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b0, "sub_0001_0002");
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "add_7fff_0001");
    do_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_8000_0001");
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, er;
    logic         rs, ec, ev;
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      if (i % 5 == 0) rb = ra;  // a == b boundary: zero result, carry 1 on sub
      model(ra, rb, rs, er, ec, ev);
      do_op(ra, rb, rs, er, ec, ev, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] er, nr;
    logic         ec, ev, nc, nv;
    int           lat;
    model(16'hA5A5, 16'h1111, 1'b1, er, ec, ev);
    model(16'h0F0F, 16'h00F1, 1'b0, nr, nc, nv);
    launch(16'hA5A5, 16'h1111, 1'b1, "hold");
    wait_valid(lat);
    // A pending command during DONE must be ignored.
    a = 16'h0F0F; b = 16'h00F1; sub = 1'b0; start_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (res_valid !== 1'b1 || start_ready !== 1'b0 || result !== er || carry !== ec) begin
        n_fail++;
        $display("FAIL hold cycle %0d: res_valid=%b start_ready=%b result=%h carry=%b want 1/0/%h/%b",
                 i, res_valid, start_ready, result, carry, er, ec);
      end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_checks++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold release idle: start_ready=%b res_valid=%b want 1/0",
               start_ready, res_valid);
    end
    tick();  // pending command accepted on this edge
    start_valid = 1'b0;
    n_checks++;
    if (start_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hold pending accept: start_ready=%b want 0", start_ready);
    end
    collect(nr, nc, nv, "hold_next");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r1, r2, got1, got2;
    logic         c1, c2, v1, v2;
    int           t1, t2;
    model(16'h1357, 16'h2468, 1'b0, r1, c1, v1);
    model(16'h4000, 16'h5000, 1'b1, r2, c2, v2);
    t1 = -1; t2 = -1; got1 = '0; got2 = '0;
    res_ready = 1'b1;
    a = 16'h1357; b = 16'h2468; sub = 1'b0; start_valid = 1'b1;
    tick();
    a = 16'h4000; b = 16'h5000; sub = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (res_valid === 1'b1) begin
        if (t1 < 0) begin t1 = c; got1 = result; end
        else if (t2 < 0) begin t2 = c; got2 = result; end
      end
    end
    start_valid = 1'b0;
    n_checks++;
    if (t1 != LAT || t2 != LAT + LAT + 2) begin
      n_fail++;
      $display("FAIL b2b timing: valid at %0d,%0d want %0d,%0d", t1, t2, LAT, 2 * LAT + 2);
    end
    n_checks++;
    if (got1 !== r1 || got2 !== r2) begin
      n_fail++;
      $display("FAIL b2b results: got %h,%h want %h,%h", got1, got2, r1, r2);
    end
    tick();
    res_ready = 1'b0;
    tick();
    n_checks++;
    if (start_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b settle idle: start_ready=%b want 1", start_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    launch(16'hFFFF, 16'hFFFF, 1'b0, "rst_mid");
    tick(); tick(); tick();  // slices 0..2 done
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0 || result !== '0 || carry !== 1'b0) begin
      n_fail++;
      $display("FAIL async reset mid run: start_ready=%b res_valid=%b result=%h carry=%b want 1/0/0000/0",
               start_ready, res_valid, result, carry);
    end
`ifdef ADDSUB_SEQ_OVF_EN
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL async reset overflow: got %b want 0", overflow);
    end
`endif
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (res_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL result after reset: res_valid high %0d cycles want 0", seen);
    end
  endtask

  task automatic test_clear();
    int seen;
    launch(16'h0123, 16'h0456, 1'b0, "clear_mid");
    tick();  // in RUN
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clear mid run: start_ready=%b res_valid=%b want 1/0", start_ready, res_valid);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (res_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL clear mid run result emitted: %0d cycles want 0", seen);
    end
    // clear and start_valid together in IDLE: the command is dropped.
    a = 16'h1111; b = 16'h2222; sub = 1'b0;
    clear = 1'b1; start_valid = 1'b1;
    tick();
    clear = 1'b0; start_valid = 1'b0;
    n_checks++;
    if (start_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear beats start: start_ready=%b want 1", start_ready);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (res_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL clear beats start result emitted: %0d cycles want 0", seen);
    end
    do_op(16'h00F0, 16'h0010, 1'b1, 16'h00E0, 1'b1, 1'b0, "after_clear");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_back_to_back();
    test_reset_mid_run();
    test_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
